mem_responder: RTL

- Memory-side responder for the CPU's memory port: accepts one read or write request at a time over a valid/ready handshake.
- Services each request from an internal word array after a programmable number of wait cycles, then returns a single-cycle response.
- Replaces the zero-wait memory when the datapath is exercised with stalls; handles word, half and byte access sizes and flags faulting accesses.

---
 rtl/mem_responder.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/mem_responder.sv
// mem_responder: single-outstanding memory responder with programmable wait
// cycles, little-endian byte/half/word lanes and fault detection.
module mem_responder #(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_fault,
    output logic        busy
);

    localparam int          AW         = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [32:0] ADDR_LIMIT = 33'(4 * DEPTH_WORDS);
    localparam logic [3:0]  CNT_LOAD   = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [3:0]  r_cnt;
    logic [3:0]  w_cnt_next;

    logic        r_we;
    logic [1:0]  r_size;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [31:0] r_rdata;
    logic        r_fault;

    logic [31:0] r_mem [DEPTH_WORDS];

    logic        w_accept;
    logic        w_enter_resp;
    logic        w_use_in;
    logic        w_we;
    logic [1:0]  w_size;
    logic [31:0] w_addr;
    logic [31:0] w_wdata;
    logic        w_fault;
    logic [AW-1:0] w_idx;
    logic [31:0] w_word;
    logic [31:0] w_shifted;
    logic [31:0] w_rd;
    logic [31:0] w_wlane;
    logic [3:0]  w_be;
    logic        w_commit;

    assign w_accept     = (r_state == IDLE) && req_valid;
    assign w_enter_resp = (w_next == RESP) && (r_state != RESP);

    // With LATENCY=1 the response is entered on the acceptance edge itself,
    // before the request has been captured, so the live inputs are used then.
    assign w_use_in = (r_state == IDLE);
    assign w_we     = w_use_in ? req_we    : r_we;
    assign w_size   = w_use_in ? req_size  : r_size;
    assign w_addr   = w_use_in ? req_addr  : r_addr;
    assign w_wdata  = w_use_in ? req_wdata : r_wdata;
    assign w_idx    = w_addr[AW+1:2];

    // Fault and lane decoding for the request about to be serviced.
    always_comb begin
        w_fault   = 1'b0;
        w_be      = 4'b0000;
        w_wlane   = w_wdata;
        w_word    = r_mem[w_idx];
        w_shifted = w_word >> {w_addr[1:0], 3'b000};
        w_rd      = 32'd0;
        if (w_size == 2'b11) begin
            w_fault = 1'b1;
        end
        if ((w_size == 2'b01) && w_addr[0]) begin
            w_fault = 1'b1;
        end
        if ((w_size == 2'b10) && (w_addr[1:0] != 2'b00)) begin
            w_fault = 1'b1;
        end
        if ({1'b0, w_addr} >= ADDR_LIMIT) begin
            w_fault = 1'b1;
        end
        case (w_size)
            2'b00: begin
                w_be    = 4'b0001 << w_addr[1:0];
                w_wlane = {4{w_wdata[7:0]}};
                w_rd    = {24'd0, w_shifted[7:0]};
            end
            2'b01: begin
                w_be    = w_addr[1] ? 4'b1100 : 4'b0011;
                w_wlane = {2{w_wdata[15:0]}};
                w_rd    = {16'd0, w_shifted[15:0]};
            end
            2'b10: begin
                w_be    = 4'b1111;
                w_wlane = w_wdata;
                w_rd    = w_word;
            end
            default: begin
                w_be    = 4'b0000;
                w_wlane = w_wdata;
                w_rd    = 32'd0;
            end
        endcase
    end

    assign w_commit = w_enter_resp && w_we && !w_fault;

    // Next-state and wait-counter logic for the IDLE -> WAIT -> RESP cycle.
    always_comb begin
        w_next     = r_state;
        w_cnt_next = r_cnt;
        case (r_state)
            IDLE: begin
                if (req_valid) begin
                    if (LATENCY == 1) begin
                        w_next = RESP;
                    end else begin
                        w_next     = WAIT;
                        w_cnt_next = CNT_LOAD;
                    end
                end
            end
            WAIT: begin
                if (r_cnt == 4'd0) begin
                    w_next = RESP;
                end else begin
                    w_cnt_next = r_cnt - 4'd1;
                end
            end
            RESP: begin
                w_next = IDLE;
            end
            default: begin
                w_next     = IDLE;
                w_cnt_next = 4'd0;
            end
        endcase
    end

    // State, counter, captured request and registered response; reset aborts any request.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
            r_cnt   <= 4'd0;
            r_we    <= 1'b0;
            r_size  <= 2'b00;
            r_addr  <= 32'd0;
            r_wdata <= 32'd0;
            r_rdata <= 32'd0;
            r_fault <= 1'b0;
        end else begin
            r_state <= w_next;
            r_cnt   <= w_cnt_next;
            if (w_accept) begin
                r_we    <= req_we;
                r_size  <= req_size;
                r_addr  <= req_addr;
                r_wdata <= req_wdata;
            end
            if (w_enter_resp) begin
                r_rdata <= (w_fault || w_we) ? 32'd0 : w_rd;
                r_fault <= w_fault;
            end
        end
    end

    // Word array: only the selected byte lanes change on the edge entering RESP.
    always_ff @(posedge clk) begin
        if (w_commit) begin
            for (int b = 0; b < 4; b++) begin
                if (w_be[b]) begin
                    r_mem[w_idx][8*b +: 8] <= w_wlane[8*b +: 8];
                end
            end
        end
    end

    assign req_ready = (r_state == IDLE);
    assign busy      = (r_state != IDLE);
    assign rsp_valid = (r_state == RESP);
    assign rsp_rdata = rsp_valid ? r_rdata : 32'd0;
    assign rsp_fault = rsp_valid ? r_fault : 1'b0;

endmodule
